// File: rtl/dp_ram_port_b_arbiter.sv
// rtl/dp_ram_port_b_arbiter.sv - two-master arbiter for dual-port RAM port B with exclusive lock
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module dp_ram_port_b_arbiter #(
  parameter int ADDR_WIDTH = 22
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [31:0]           m0_wdata_i,
  input  logic                  m0_lock_i,
  output logic                  m0_rvalid_o,
  output logic [31:0]           m0_rdata_o,
  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [31:0]           m1_wdata_i,
  input  logic                  m1_lock_i,
  output logic                  m1_rvalid_o,
  output logic [31:0]           m1_rdata_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  localparam logic [1:0] ARB  = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic        rsp_valid_q, rsp_id_q, rsp_we_q;
  logic        gnt0, gnt1;
  logic [31:0] rsp_data;

  // Grants are held off while reset is asserted so the port is quiet.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst_i) begin
      case (state_q)
        OWN0:    gnt0 = m0_req_i;
        OWN1:    gnt1 = m1_req_i;
        default: begin
          if (m0_req_i && m1_req_i) begin
`ifdef RAM_ARB_RR_EN
            gnt0 = last_q;
            gnt1 = ~last_q;
`else
            gnt0 = 1'b1;
`endif
          end else begin
            gnt0 = m0_req_i;
            gnt1 = m1_req_i;
          end
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OWN0:    if (!m0_lock_i) state_d = ARB;
      OWN1:    if (!m1_lock_i) state_d = ARB;
      default: begin
        state_d = ARB;
        if (gnt0 && m0_lock_i)      state_d = OWN0;
        else if (gnt1 && m1_lock_i) state_d = OWN1;
      end
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (gnt0)      last_d = 1'b0;
    else if (gnt1) last_d = 1'b1;
  end

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;
  assign ram_en_o    = gnt0 | gnt1;
  assign ram_addr_o  = gnt0 ? m0_addr_i  : (gnt1 ? m1_addr_i  : '0);
  assign ram_we_o    = gnt0 ? m0_we_i    : (gnt1 ? m1_we_i    : 1'b0);
  assign ram_be_o    = gnt0 ? m0_be_i    : (gnt1 ? m1_be_i    : 4'h0);
  assign ram_wdata_o = gnt0 ? m0_wdata_i : (gnt1 ? m1_wdata_i : 32'h0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ARB;
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      rsp_valid_q <= ram_en_o;
      rsp_id_q    <= gnt1;
      rsp_we_q    <= ram_we_o;
    end
  end

  // RAM output is stale after a write, so write responses return zero.
  assign rsp_data    = rsp_we_q ? 32'h0 : ram_rdata_i;
  assign m0_rvalid_o = rsp_valid_q & ~rsp_id_q;
  assign m1_rvalid_o = rsp_valid_q & rsp_id_q;
  assign m0_rdata_o  = m0_rvalid_o ? rsp_data : 32'h0;
  assign m1_rdata_o  = m1_rvalid_o ? rsp_data : 32'h0;

endmodule

// File: tb/tb_dp_ram_port_b_arbiter.sv
// tb/tb_dp_ram_port_b_arbiter.sv - scoreboard bench for dp_ram_port_b_arbiter
module tb_dp_ram_port_b_arbiter;
  localparam int AW = 22;

  logic clk = 1'b0, rst = 1'b1;
  logic m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [3:0] m0_be, m1_be;
  logic [31:0] m0_wdata, m1_wdata;
  logic m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [3:0] ram_be_o;
  logic [31:0] ram_wdata_o, ram_rdata;

  typedef struct { logic id; logic [31:0] data; int due; } exp_t;
  exp_t sb[$];
  logic [7:0] ram_mem [0:4095];
  logic [7:0] ref_mem [0:4095];
  int n_chk = 0, n_fail = 0, cyc_n = 0;

  always #5 clk = ~clk;

  dp_ram_port_b_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
    .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_lock_i(m0_lock),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
    .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_lock_i(m1_lock),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
    .ram_be_o(ram_be_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata)
  );

  // Port B of the testbench RAM: one-cycle read latency, output holds on writes.
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) ram_mem[{ram_addr_o[11:2], 2'(b)}] <= ram_wdata_o[8*b +: 8];
      end else begin
        ram_rdata <= {ram_mem[{ram_addr_o[11:2], 2'd3}], ram_mem[{ram_addr_o[11:2], 2'd2}],
                      ram_mem[{ram_addr_o[11:2], 2'd1}], ram_mem[{ram_addr_o[11:2], 2'd0}]};
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc_n, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
    logic [11:0] w;
    w = {a[11:2], 2'b00};
    return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
  endfunction

  task automatic ref_wr(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [11:0] w;
    w = {a[11:2], 2'b00};
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[w + 12'(b)] = d[8*b +: 8];
  endtask

  task automatic drv(input int n, input logic req, input logic we, input logic [AW-1:0] addr,
                     input logic [3:0] be, input logic [31:0] wd, input logic lock);
    if (n == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_be = be; m0_wdata = wd; m0_lock = lock;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_be = be; m1_wdata = wd; m1_lock = lock;
    end
  endtask

  task automatic idle();
    drv(0, 0, 0, '0, 4'h0, 32'h0, 0);
    drv(1, 0, 0, '0, 4'h0, 32'h0, 0);
  endtask

  // One clock cycle: check responses due now, check grant/RAM mux, queue expected response.
  task automatic cyc(input logic eg0, input logic eg1);
    exp_t e;
    logic [AW-1:0] a;
    logic we;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].due < cyc_n) begin
      check_eq("rsp_lost", 64'(sb[0].due), 64'(cyc_n));
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].due == cyc_n) begin
      e = sb.pop_front();
      check_eq("rvalid", {m1_rvalid_o, m0_rvalid_o}, e.id ? 2'b10 : 2'b01);
      check_eq("rdata", e.id ? m1_rdata_o : m0_rdata_o, e.data);
      check_eq("rdata_other", e.id ? m0_rdata_o : m1_rdata_o, 32'h0);
    end else begin
      check_eq("rvalid_idle", {m1_rvalid_o, m0_rvalid_o}, 2'b00);
    end
    check_eq("gnt", {m1_gnt_o, m0_gnt_o}, {eg1, eg0});
    if (eg0 || eg1) begin
      a  = eg1 ? m1_addr : m0_addr;
      we = eg1 ? m1_we : m0_we;
      check_eq("ram_cmd", {ram_en_o, ram_we_o, ram_be_o, ram_addr_o},
               {1'b1, we, eg1 ? m1_be : m0_be, a});
      if (we) check_eq("ram_wdata", ram_wdata_o, eg1 ? m1_wdata : m0_wdata);
      e.id = eg1; e.due = cyc_n + 1;
      e.data = we ? 32'h0 : ref_rd(a);
      if (we) ref_wr(a, eg1 ? m1_be : m0_be, eg1 ? m1_wdata : m0_wdata);
      sb.push_back(e);
    end else begin
      check_eq("ram_idle", {ram_en_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o}, '0);
    end
    @(posedge clk);
    cyc_n++;
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq(tag, {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, ram_en_o, ram_we_o,
                   ram_be_o, ram_addr_o}, '0);
    check_eq({tag, "_data"}, {m0_rdata_o, m1_rdata_o}, 64'h0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    ram_mem[12'h100] = 8'hEF; ram_mem[12'h101] = 8'hBE; ram_mem[12'h102] = 8'hAD; ram_mem[12'h103] = 8'hDE;
    ref_mem[12'h100] = 8'hEF; ref_mem[12'h101] = 8'hBE; ref_mem[12'h102] = 8'hAD; ref_mem[12'h103] = 8'hDE;
    ram_rdata = 32'h0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single read of the known word
    drv(0, 1, 0, 22'h100, 4'hF, 0, 0); cyc(1, 0);
    idle(); cyc(0, 0);
    // Partial write then read-back by m1
    drv(1, 1, 1, 22'h200, 4'b0011, 32'h12345678, 0); cyc(0, 1);
    drv(1, 1, 0, 22'h200, 4'hF, 0, 0); cyc(0, 1);
    idle(); cyc(0, 0);
    // Continuous contention
    drv(0, 1, 0, 22'h10, 4'hF, 0, 0); drv(1, 1, 0, 22'h20, 4'hF, 0, 0);
`ifdef RAM_ARB_RR_EN
    cyc(1, 0); cyc(0, 1); cyc(1, 0); cyc(0, 1);
`else
    cyc(1, 0); cyc(1, 0); cyc(1, 0); cyc(1, 0);
`endif
    idle(); cyc(0, 0);
    // m1 locks the port for three transfers while m0 waits
    drv(1, 1, 0, 22'h30, 4'hF, 0, 1); cyc(0, 1);
    drv(0, 1, 0, 22'h40, 4'hF, 0, 0);
    drv(1, 1, 1, 22'h34, 4'hF, 32'hCAFE0001, 1); cyc(0, 1);
    drv(1, 1, 0, 22'h34, 4'hF, 0, 0); cyc(0, 1);
    cyc(1, 0);
    drv(0, 0, 0, 0, 0, 0, 0); cyc(0, 1);
    idle(); cyc(0, 0);
    // Lock without request has no effect
    drv(0, 1, 0, 22'h44, 4'hF, 0, 0); drv(1, 0, 0, 0, 0, 0, 1); cyc(1, 0);
    drv(1, 0, 0, 0, 0, 0, 0); cyc(1, 0);
    // m0 lock holds off m1 even when round-robin would favour it
    drv(0, 1, 0, 22'h48, 4'hF, 0, 1); cyc(1, 0);
    drv(1, 1, 0, 22'h4C, 4'hF, 0, 0); cyc(1, 0);
    drv(0, 1, 0, 22'h50, 4'hF, 0, 0); cyc(1, 0);
    drv(0, 0, 0, 0, 0, 0, 0); cyc(0, 1);
    idle(); cyc(0, 0);
    // Back-to-back reads
    drv(0, 1, 0, 22'h0, 4'hF, 0, 0); cyc(1, 0);
    drv(0, 1, 0, 22'h4, 4'hF, 0, 0); cyc(1, 0);
    drv(0, 1, 0, 22'h8, 4'hF, 0, 0); cyc(1, 0);
    idle(); cyc(0, 0);
    cyc(0, 0);
    // Reset with a response in flight and the port locked by m0
    drv(0, 1, 0, 22'h100, 4'hF, 0, 1); cyc(1, 0);
    idle();
    rst = 1'b1;
    @(negedge clk);
    check_quiet("midrst");
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0, 0);
    drv(0, 1, 0, 22'h60, 4'hF, 0, 0); drv(1, 1, 0, 22'h64, 4'hF, 0, 0); cyc(1, 0);
    drv(0, 0, 0, 0, 0, 0, 0); cyc(0, 1);
    idle(); cyc(0, 0);
    cyc(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
